// File: rtl/dff_reg_arbiter.sv
// -----------------------------------------------------------------------------
// dff_reg_arbiter
//
// Two requesters share one WIDTH-bit register. A three-state FSM (IDLE, OWN0,
// OWN1) grants ownership to one requester at a time. While the owner keeps
// requesting, its data is written into the register on every rising edge.
//
// Ties are broken by a one-bit pointer, "last", which records the requester
// that was granted most recently. The requester that is not "last" wins a tie.
//
// A hold counter limits how long one owner can keep the register while the
// other requester waits. After MAX_HOLD writes with a competitor present,
// ownership is forced over. On a handover, whether voluntary or forced, the
// new owner is granted on the same edge, so there is no idle cycle between
// owners.
//
// Parameters
//   WIDTH     width of the shared register and of both data inputs
//   MAX_HOLD  maximum number of consecutive owned cycles while the other
//             requester waits (legal range 2..15)
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous, active-low reset
//   req0/1    ownership requests
//   d0/d1     write data; only the current owner's data is used
//   gnt0/1    registered ownership indication (mutually exclusive)
//   q         registered shared-register contents
// -----------------------------------------------------------------------------
module dff_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  // Saturation value of the hold counter; reaching it with a competitor
  // waiting triggers the forced handover.
  localparam logic [3:0] HOLD_SAT = 4'(MAX_HOLD - 1);

  logic [1:0]       state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             last, last_next;
  logic [WIDTH-1:0] q_next;

  // These describe the current owner and its competitor, so that one piece
  // of OWN logic serves both OWN states.
  logic             own_req, oth_req;
  logic [WIDTH-1:0] own_d;
  logic [1:0]       oth_state;
  logic             oth_id;

  always_comb begin
    own_req   = (state == OWN1) ? req1 : req0;
    oth_req   = (state == OWN1) ? req0 : req1;
    own_d     = (state == OWN1) ? d1   : d0;
    oth_state = (state == OWN1) ? OWN0 : OWN1;
    oth_id    = (state == OWN0);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    last_next  = last;
    q_next     = q;

    case (state)
      IDLE: begin
        // The register is never written while idle. A tie goes to the
        // requester that was not granted most recently.
        if (req0 && (!req1 || last)) begin
          state_next = OWN0;
          last_next  = 1'b0;
          cnt_next   = '0;
        end else if (req1) begin
          state_next = OWN1;
          last_next  = 1'b1;
          cnt_next   = '0;
        end
      end

      OWN0, OWN1: begin
        if (own_req) begin
          q_next = own_d;
          if (oth_req && (cnt == HOLD_SAT)) begin
            // Forced handover. The owner still gets this final write.
            state_next = oth_state;
            last_next  = oth_id;
            cnt_next   = '0;
          end else if (cnt != HOLD_SAT) begin
            cnt_next = cnt + 4'd1;
          end
        end else if (oth_req) begin
          // Voluntary release straight to the waiting requester.
          state_next = oth_state;
          last_next  = oth_id;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only. The reset is
  // asynchronous, so outputs clear as soon as reset_n falls, without waiting
  // for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      q     <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      last  <= last_next;
      q     <= q_next;
      gnt0  <= (state_next == OWN0);
      gnt1  <= (state_next == OWN1);
    end
  end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_reg_arbiter
//
// Self-checking bench for dff_reg_arbiter (WIDTH=8, MAX_HOLD=4). It contains
// reset and async-reset sequences, a cycle-by-cycle vector table, and
// randomized traffic compared against an owner/tenure reference model.
// -----------------------------------------------------------------------------
module tb_dff_reg_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req0, req1;
  logic [WIDTH-1:0] d0, d1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] q;

  dff_reg_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .d0      (d0),
    .d1      (d1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .q       (q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       g0, g1;
    logic [7:0] q;
  } vec_t;

  function automatic vec_t mk(logic r0, logic r1, logic [7:0] a, logic [7:0] b,
                              logic g0, logic g1, logic [7:0] eq);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = a; v.d1 = b;
    v.g0 = g0; v.g1 = g1; v.q = eq;
    return v;
  endfunction

  // Reference model. The owner is -1 for none, or 0 or 1. "writes" counts the
  // writes made in the current tenure and does not saturate.
  int         m_owner, m_last, m_writes;
  logic [7:0] m_q;

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_writes = 0; m_q = 8'h00;
  endtask

  task automatic model_step(input logic r0, input logic r1,
                            input logic [7:0] a, input logic [7:0] b);
    logic       r[2];
    logic [7:0] d[2];
    int         x, y, w;
    r[0] = r0; r[1] = r1; d[0] = a; d[1] = b;
    if (m_owner < 0) begin
      w = -1;
      if (r[0] && r[1]) w = 1 - m_last;
      else if (r[0])    w = 0;
      else if (r[1])    w = 1;
      if (w >= 0) begin m_owner = w; m_last = w; m_writes = 0; end
    end else begin
      x = m_owner; y = 1 - x;
      if (r[x]) begin
        m_q = d[x];
        if (r[y] && m_writes >= MAX_HOLD - 1) begin
          m_owner = y; m_last = y; m_writes = 0;
        end else begin
          m_writes++;
        end
      end else if (r[y]) begin
        m_owner = y; m_last = y; m_writes = 0;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  vec_t vecs[22];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic cur_g0, cur_g1;
    int   s0, s1;

    // Reset held for two edges with both requests high.
    reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1; d0 = 8'h5A; d1 = 8'hC3;
    for (int e = 0; e < 2; e++) begin
      cycle();
      check($sformatf("rst%0d gnt0", e), gnt0, 0);
      check($sformatf("rst%0d gnt1", e), gnt1, 0);
      check($sformatf("rst%0d q", e),    q,    0);
    end
    reset_n = 1'b1;
    cycle();
    check("rst_rel gnt0", gnt0, 1);
    check("rst_rel gnt1", gnt1, 0);

    // Vector table, applied one cycle per row starting from reset.
    vecs[0]  = mk(1, 0, 8'hA5, 8'h00, 1, 0, 8'h00);
    vecs[1]  = mk(1, 0, 8'hA5, 8'h00, 1, 0, 8'hA5);
    vecs[2]  = mk(0, 0, 8'hA5, 8'h00, 0, 0, 8'hA5);
    vecs[3]  = mk(0, 0, 8'hFF, 8'hEE, 0, 0, 8'hA5);
    vecs[4]  = mk(1, 1, 8'h11, 8'h22, 0, 1, 8'hA5);
    vecs[5]  = mk(1, 1, 8'h11, 8'h22, 0, 1, 8'h22);
    vecs[6]  = mk(1, 1, 8'h11, 8'h22, 0, 1, 8'h22);
    vecs[7]  = mk(1, 1, 8'h11, 8'h22, 0, 1, 8'h22);
    vecs[8]  = mk(1, 1, 8'h11, 8'h22, 1, 0, 8'h22);
    vecs[9]  = mk(1, 1, 8'h11, 8'h22, 1, 0, 8'h11);
    vecs[10] = mk(1, 1, 8'h11, 8'h22, 1, 0, 8'h11);
    vecs[11] = mk(1, 1, 8'h11, 8'h22, 1, 0, 8'h11);
    vecs[12] = mk(1, 1, 8'h11, 8'h22, 0, 1, 8'h11);
    vecs[13] = mk(1, 0, 8'h77, 8'h99, 1, 0, 8'h11);
    vecs[14] = mk(1, 0, 8'h77, 8'h99, 1, 0, 8'h77);
    vecs[15] = mk(1, 0, 8'h78, 8'h99, 1, 0, 8'h78);
    vecs[16] = mk(1, 0, 8'h79, 8'h99, 1, 0, 8'h79);
    vecs[17] = mk(1, 0, 8'h7A, 8'h99, 1, 0, 8'h7A);
    vecs[18] = mk(1, 1, 8'h7B, 8'h55, 0, 1, 8'h7B);
    vecs[19] = mk(0, 1, 8'h7B, 8'h55, 0, 1, 8'h55);
    vecs[20] = mk(0, 0, 8'h7B, 8'h55, 0, 0, 8'h55);
    vecs[21] = mk(1, 1, 8'h01, 8'h02, 1, 0, 8'h55);

    apply_reset();
    for (int i = 0; i < 22; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1; d0 = vecs[i].d0; d1 = vecs[i].d1;
      cycle();
      check($sformatf("vec%0d gnt0", i), gnt0, vecs[i].g0);
      check($sformatf("vec%0d gnt1", i), gnt1, vecs[i].g1);
      check($sformatf("vec%0d q", i),    q,    vecs[i].q);
    end

    // Asynchronous reset while owning: outputs must clear before any edge.
    apply_reset();
    req0 = 1'b1; req1 = 1'b0; d0 = 8'h3C; d1 = 8'hAA;
    cycle();
    cycle();
    check("async pre gnt0", gnt0, 1);
    check("async pre q",    q,    8'h3C);
    #2 reset_n = 1'b0;
    #1;
    check("async gnt0", gnt0, 0);
    check("async q",    q,    0);
    @(negedge clk);
    reset_n = 1'b1; req0 = 1'b0; req1 = 1'b1;
    cycle();
    check("async rel gnt1", gnt1, 1);
    check("async rel q",    q,    0);

    // Randomized traffic against the reference model.
    apply_reset();
    model_reset();
    cur_g0 = 1'b0; cur_g1 = 1'b0; s0 = 0; s1 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        #2 reset_n = 1'b0;
        #1;
        check("rnd async gnt0", gnt0, 0);
        check("rnd async gnt1", gnt1, 0);
        check("rnd async q",    q,    0);
        model_reset();
        cur_g0 = 1'b0; cur_g1 = 1'b0; s0 = 0; s1 = 0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      s0 = (cur_g0 && req1) ? s0 + 1 : 0;
      s1 = (cur_g1 && req0) ? s1 + 1 : 0;
      @(posedge clk);
      model_step(req0, req1, d0, d1);
      @(negedge clk);
      check($sformatf("rnd%0d gnt0", i), gnt0, (m_owner == 0));
      check($sformatf("rnd%0d gnt1", i), gnt1, (m_owner == 1));
      check($sformatf("rnd%0d q", i),    q,    m_q);
      check($sformatf("rnd%0d mutex", i), gnt0 & gnt1, 0);
      check($sformatf("rnd%0d hold0 over", i), (s0 > MAX_HOLD), 0);
      check($sformatf("rnd%0d hold1 over", i), (s1 > MAX_HOLD), 0);
      cur_g0 = gnt0;
      cur_g1 = gnt1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dff_reg_arbiter.md
DFF_REG_ARBITER -- requirements
Module: dff_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, width of the shared register and both data inputs.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive owned cycles before forced handover when the other requester is waiting; legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 req0  input  1  requester 0 requests ownership of the shared register.
REQ-006 req1  input  1  requester 1 requests ownership of the shared register.
REQ-007 d0  input  WIDTH  write data from requester 0.
REQ-008 d1  input  WIDTH  write data from requester 1.
REQ-009 gnt0  output  1  requester 0 owns the register; registered.
REQ-010 gnt1  output  1  requester 1 owns the register; registered.
REQ-011 q  output  WIDTH  shared register contents; registered.

Function
REQ-012 Three-state FSM: IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1); gnt0 and gnt1 never both 1.
REQ-013 Priority pointer last (1 bit) records the most recently granted requester; on a tie, the requester not equal to last wins.
REQ-014 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> winner per REQ-013; neither -> stay IDLE.
REQ-015 Grant latency: a request sampled in IDLE gives gnt high exactly one cycle later.
REQ-016 OWNx with reqx=1 at an edge: q <= dx at that edge.
REQ-017 OWNx with reqx=0 at an edge: q holds; the next state is OWNy if reqy=1, otherwise IDLE; no idle bubble is inserted on handover.
REQ-018 Hold counter (4 bits) clears on entry to any OWN state and increments on each edge spent in OWN while the owner keeps requesting; it saturates at MAX_HOLD-1.
REQ-019 Forced handover: OWNx with counter==MAX_HOLD-1, reqx=1 and reqy=1 -> q <= dx at that edge (final write), then next state is OWNy.
REQ-020 Owner with no competitor: ownership continues indefinitely, and the counter stays saturated.
REQ-021 last updates on every entry to OWN0 (last=0) or OWN1 (last=1).
REQ-022 Data inputs of the non-owner are ignored; q never changes in IDLE.
REQ-023 A request deasserted before its grant arrives is not queued; if the FSM has already entered OWNx, REQ-017 applies on the next edge.

Reset
REQ-024 With reset_n=0: state=IDLE, gnt0=0, gnt1=0, q=0, counter=0, last=1 (requester 0 wins the first tie), all immediately and without waiting for clk.
REQ-025 Reset asserted mid-ownership aborts the ownership with no partial write; after release the FSM resumes from IDLE on the first rising edge with reset_n=1.

Verification
REQ-026 Reset: hold reset_n=0 for 2 edges with req0=req1=1 -> gnt0=gnt1=0 and q=0 throughout; release -> gnt0=1 one edge later (tie, last=1).
REQ-027 Single requester: req0=1, d0=8'hA5 from IDLE -> gnt0 at edge 1, q=8'hA5 at edge 2; drop req0 -> IDLE and gnt0=0 one edge later, q stays 8'hA5.
REQ-028 Contention and forced handover, MAX_HOLD=4: req0=req1=1 continuously, d0=8'h11, d1=8'h22 -> gnt0 for 4 cycles, then gnt1 for 4 cycles, alternating; q alternates 8'h11/8'h22 with no IDLE gap.
REQ-029 Voluntary release: in OWN1, drop req1 while req0=1 -> gnt1 falls and gnt0 rises on the same edge; q is not written by d1 on that edge.
REQ-030 Async reset mid-operation: in OWN0 with q=8'h3C, pulse reset_n low between edges -> gnt0=0 and q=0 immediately, before the next clk edge.
REQ-031 Mutual exclusion: randomized req0/req1/d0/d1 for 1000 cycles -> gnt0&gnt1 never 1, q changes only per REQ-016/REQ-019, no owner exceeds MAX_HOLD cycles while the other requests.
